// File: rtl/slot_io_responder.sv
// Dock slot I/O responder: synchronizes async bus strobes and hands each transfer to a local register port.
// Optional local-ack timeout is built only when SLOT_RESP_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no transfer; waiting for cs_s with a single strobe
// S_SETUP  | address/data captured; wait states counting down
// S_ACCESS | reg_req asserted until reg_ack (or timeout); error passes through
// S_DONE   | dev_ready_n low until the dock drops cs
module slot_io_responder #(
   parameter int ADDR_W         = 4,
   parameter int WAIT_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              rdata_oe,
   output logic              dev_ready_n,
   output logic              reg_req,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   input  logic              reg_ack,
   output logic              timeout_flag
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES);

   if (WAIT_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("slot_io_responder: WAIT_CYCLES must be >= 0 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]        cs_sync;
   logic [1:0]        rd_sync;
   logic [1:0]        wr_sync;
   logic              cs_s;
   logic              rd_s;
   logic              wr_s;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WCNT_W-1:0] wait_cnt;
   logic              err;
   logic              start;
   logic              ack_take;
   logic              tmo_hit;
   logic              tmo_expired;

   // Strobes are active-low on the bus; carried active-true from the first flop on
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync <= 2'b00;
         rd_sync <= 2'b00;
         wr_sync <= 2'b00;
      end else begin
         cs_sync <= {cs_sync[0], cs};
         rd_sync <= {rd_sync[0], ~rd_n};
         wr_sync <= {wr_sync[0], ~wr_n};
      end
   end

   assign cs_s = cs_sync[1];
   assign rd_s = rd_sync[1];
   assign wr_s = wr_sync[1];

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ack_take  = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cs_s && (rd_s || wr_s)) begin
               state_nxt = S_SETUP;
               start     = 1'b1;
            end
         end
         S_SETUP: begin
            if (!cs_s) begin
               state_nxt = S_IDLE;
            end else if (wait_cnt == '0) begin
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // Dock abort wins over a same-cycle acknowledge
            if (!cs_s) begin
               state_nxt = S_IDLE;
            end else if (err) begin
               state_nxt = S_DONE;
            end else if (reg_ack) begin
               state_nxt = S_DONE;
               ack_take  = 1'b1;
            end else if (tmo_expired) begin
               state_nxt = S_DONE;
               tmo_hit   = 1'b1;
            end
         end
         S_DONE: begin
            if (!cs_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         err         <= 1'b0;
         reg_we      <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= 8'h00;
         reg_req     <= 1'b0;
         rdata       <= 8'h00;
         rdata_oe    <= 1'b0;
         dev_ready_n <= 1'b1;
      end else begin
         state <= state_nxt;

         if (start) begin
            err       <= rd_s & wr_s;
            reg_we    <= wr_s & ~rd_s;
            reg_addr  <= addr;
            reg_wdata <= wdata;
            wait_cnt  <= WAIT_LOAD;
         end else if (state == S_SETUP && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end

         // err is already settled whenever ACCESS is entered, so no request leaks on an error
         reg_req <= (state_nxt == S_ACCESS) && !err;

         if (ack_take && !reg_we) begin
            rdata <= reg_rdata;
         end else if (state == S_ACCESS && state_nxt == S_DONE &&
                      (err || (tmo_hit && !reg_we))) begin
            rdata <= 8'hFF;
         end

         rdata_oe    <= (state_nxt == S_DONE) && !err && !reg_we;
         dev_ready_n <= (state_nxt != S_DONE);
      end
   end

`ifdef SLOT_RESP_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCNT_W-1:0] TMO_LOAD = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [TCNT_W-1:0] tmo_cnt;
   logic              tmo_flag_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt    <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         if (state != S_ACCESS && state_nxt == S_ACCESS) begin
            tmo_cnt <= TMO_LOAD;
         end else if (state == S_ACCESS && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
         if (tmo_hit) begin
            tmo_flag_q <= 1'b1;
         end
      end
   end

   assign tmo_expired  = (tmo_cnt == '0);
   assign timeout_flag = tmo_flag_q;
`else
   assign tmo_expired  = 1'b0;
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_slot_io_responder.sv
// Scoreboard bench for slot_io_responder: directed transfers push expectations, a monitor checks each completion.
`timescale 1ns/1ps
module tb_slot_io_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs;
   logic       rd_n;
   logic       wr_n;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rdata_oe;
   logic       dev_ready_n;
   logic       reg_req;
   logic       reg_we;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       reg_ack;
   logic       timeout_flag;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SLOT_RESP_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   slot_io_responder #(.ADDR_W(4), .WAIT_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .cs(cs), .rd_n(rd_n), .wr_n(wr_n), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rdata_oe(rdata_oe), .dev_ready_n(dev_ready_n),
      .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack), .timeout_flag(timeout_flag)
   );

   typedef struct {
      logic [7:0] rdata;
      logic       oe;
      logic       tflag;
      int         lat;
      int         req_cyc;
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   mon_cyc;
   int   mon_req;
   logic prev_cs;
   logic prev_drn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_reset_values();
      check("rst_dev_ready_n", dev_ready_n, 1);
      check("rst_reg_req", reg_req, 0);
      check("rst_reg_we", reg_we, 0);
      check("rst_rdata_oe", rdata_oe, 0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_reg_addr", reg_addr, 4'h0);
      check("rst_reg_wdata", reg_wdata, 8'h00);
      check("rst_timeout_flag", timeout_flag, 0);
   endtask

   task automatic push(input logic [7:0] rd, input logic oe, input logic tf, input int lat,
                       input int rq, input logic we, input logic [3:0] a, input logic [7:0] d);
      exp_t e;
      e.rdata = rd; e.oe = oe; e.tflag = tf; e.lat = lat;
      e.req_cyc = rq; e.we = we; e.addr = a; e.wdata = d;
      exp_q.push_back(e);
   endtask

   task automatic start_xfer(input bit is_rd, input bit is_wr, input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      rd_n  = !is_rd;
      wr_n  = !is_wr;
      cs    = 1'b1;
   endtask

   task automatic wait_req();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (reg_req !== 1'b1 && n < 300);
      check("req_seen", reg_req, 1);
   endtask

   task automatic respond(input int delay, input logic [7:0] d);
      wait_req();
      repeat (delay) @(negedge clk);
      reg_rdata = d;
      reg_ack   = 1'b1;
      @(negedge clk);
      reg_ack   = 1'b0;
   endtask

   task automatic end_xfer();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dev_ready_n !== 1'b0 && n < 300);
      check("done_reached", dev_ready_n, 0);
      @(negedge clk);
      cs   = 1'b0;
      rd_n = 1'b1;
      wr_n = 1'b1;
      repeat (2) @(negedge clk);
      check("drn_hold_until_cs_s_low", dev_ready_n, 0);
      @(negedge clk);
      check("drn_release", dev_ready_n, 1);
      check("oe_release", rdata_oe, 0);
   endtask

   // Monitor: latency counted in clocks from the raw cs rise (2 synchronizer clocks + WAIT+3)
   initial begin
      prev_cs  = 1'b0;
      prev_drn = 1'b1;
      mon_cyc  = 0;
      mon_req  = 0;
      forever begin
         @(negedge clk);
         #1;
         if (cs === 1'b1 && prev_cs !== 1'b1) begin
            mon_cyc = 0;
            mon_req = 0;
         end else begin
            mon_cyc++;
         end
         if (reg_req === 1'b1) mon_req++;
         if (dev_ready_n === 1'b0 && prev_drn === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: dev_ready_n low with no transfer expected (t=%0t)", $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("latency", mon_cyc, mon_e.lat);
               check("req_cycles", mon_req, mon_e.req_cyc);
               check("rdata", rdata, mon_e.rdata);
               check("rdata_oe", rdata_oe, mon_e.oe);
               check("timeout_flag", timeout_flag, mon_e.tflag);
               check("reg_we", reg_we, mon_e.we);
               check("reg_addr", reg_addr, mon_e.addr);
               check("reg_wdata", reg_wdata, mon_e.wdata);
            end
         end
         prev_cs  = cs;
         prev_drn = dev_ready_n;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
      addr = 4'h0; wdata = 8'h00; reg_rdata = 8'h00; reg_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Read, ack in first ACCESS cycle
      push(8'hA5, 1, 0, 7, 1, 0, 4'h3, 8'h00);
      start_xfer(1, 0, 4'h3, 8'h00);
      respond(0, 8'hA5);
      end_xfer();

      // Write, ack after 4 cycles; reg_rdata must not reach rdata
      push(8'hA5, 0, 0, 11, 5, 1, 4'h7, 8'h3C);
      start_xfer(0, 1, 4'h7, 8'h3C);
      respond(4, 8'h5A);
      end_xfer();

      // Both strobes: protocol error, no request
      push(8'hFF, 0, 0, 7, 0, 0, 4'h2, 8'h11);
      start_xfer(1, 1, 4'h2, 8'h11);
      end_xfer();

      // Abort during ACCESS, late ack while idle must be ignored
      start_xfer(1, 0, 4'h4, 8'h00);
      wait_req();
      cs   = 1'b0;
      rd_n = 1'b1;
      repeat (3) @(negedge clk);
      reg_rdata = 8'h77;
      reg_ack   = 1'b1;
      @(negedge clk);
      reg_ack   = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_rdata_kept", rdata, 8'hFF);
      check("abort_req_low", reg_req, 0);
      check("abort_drn_high", dev_ready_n, 1);

      // Reset pulse in SETUP with cs held; restart only after resynchronization
      push(8'hC3, 1, 0, 11, 1, 0, 4'h9, 8'h00);
      start_xfer(1, 0, 4'h9, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_values();
      repeat (2) @(negedge clk);
      check("resync_no_early_start", reg_addr, 4'h0);
      respond(0, 8'hC3);
      end_xfer();

      if (TMO_EN) begin
         push(8'hFF, 1, 1, 70, 64, 0, 4'h5, 8'h00);
         start_xfer(1, 0, 4'h5, 8'h00);
         end_xfer();
      end

      // Good read; timeout flag is sticky when the timeout is built
      push(8'h5E, 1, TMO_EN, 7, 1, 0, 4'hA, 8'h00);
      start_xfer(1, 0, 4'hA, 8'h00);
      respond(0, 8'h5E);
      end_xfer();

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/slot_io_responder.md
SLOT_IO_RESPONDER -- requirements
Module: slot_io_responder

Interface
REQ-001 Parameter ADDR_W, default 4: register-select width.
REQ-002 Parameter WAIT_CYCLES, default 2: setup wait states before the local request (0 allowed).
REQ-003 Parameter TIMEOUT_CYCLES, default 64: local-ack timeout; used only with the macro in REQ-027.
REQ-004 Ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005 Bus ports, from the dock: cs  in  1  slot select, active-high, async; rd_n  in  1  read strobe, async; wr_n  in  1  write strobe, async; addr  in  ADDR_W  register select; wdata  in  8  write data.
REQ-006 Bus ports, to the dock: rdata  out  8  read data; rdata_oe  out  1  read-data drive enable; dev_ready_n  out  1  low = transfer complete, high = wait.
REQ-007 Local ports: reg_req  out  1  request; reg_we  out  1  write qualifier; reg_addr  out  ADDR_W; reg_wdata  out  8; reg_rdata  in  8; reg_ack  in  1  one-cycle acknowledge.
REQ-008 Status port: timeout_flag  out  1  sticky timeout indicator.

Function
REQ-009 cs, rd_n and wr_n SHALL each pass through a two-flop synchronizer (cs_s, rd_s, wr_s, active-true); the FSM uses only the synchronized values.
REQ-010 addr and wdata SHALL be captured on the IDLE->SETUP transition and held constant on reg_addr/reg_wdata until return to IDLE.
REQ-011 States SHALL be IDLE, SETUP, ACCESS, DONE.
REQ-012 IDLE: dev_ready_n=1, reg_req=0, rdata_oe=0; go to SETUP when cs_s=1 and exactly one of rd_s/wr_s=1; latch reg_we=wr_s.
REQ-013 IDLE with cs_s=1 and neither strobe active: remain in IDLE.
REQ-014 IDLE with cs_s=1 and both strobes active: protocol error; go to SETUP flagged as error; no local request; no write.
REQ-015 SETUP: count WAIT_CYCLES clocks, then go to ACCESS; WAIT_CYCLES=0 gives exactly one cycle in SETUP.
REQ-016 ACCESS: reg_req=1 until the cycle reg_ack=1; on that cycle, for a read, register reg_rdata into rdata; reg_req=0 next cycle; go to DONE.
REQ-017 An error transfer passes ACCESS in one cycle without reg_req, sets rdata=8'hFF, and goes to DONE.
REQ-018 DONE: dev_ready_n=0; rdata_oe=1 only for a non-error read; hold until cs_s=0, then go to IDLE with dev_ready_n=1 the following cycle.
REQ-019 If cs_s=0 in SETUP or ACCESS: abort to IDLE next cycle; reg_req=0; a later reg_ack SHALL be ignored.
REQ-020 reg_ack outside ACCESS SHALL be ignored.
REQ-021 Minimum read latency from the cs_s rise to dev_ready_n low SHALL be WAIT_CYCLES+3 clocks when reg_ack returns in the first ACCESS cycle.
REQ-022 rdata SHALL hold its last value outside DONE.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE: dev_ready_n=1, reg_req=0, reg_we=0, rdata_oe=0, rdata=8'h00, reg_addr=0, reg_wdata=0, timeout_flag=0, counters=0, synchronizer flops to inactive.
REQ-024 Reset mid-transfer SHALL drop reg_req the next cycle; a reg_ack arriving during or after reset is ignored.
REQ-025 After rst falls, a cs held high SHALL start a transfer only after resynchronization (at least 2 clocks).

Configuration
REQ-026 Macro SLOT_RESP_TIMEOUT_EN SHALL control the local-ack timeout.
REQ-027 With SLOT_RESP_TIMEOUT_EN defined: if reg_ack is absent for TIMEOUT_CYCLES clocks in ACCESS, drop reg_req, set rdata=8'hFF for reads, set timeout_flag (sticky until rst), and go to DONE.
REQ-028 With SLOT_RESP_TIMEOUT_EN undefined: ACCESS waits indefinitely, timeout_flag is tied 0, and no timeout counter is built.

Verification
REQ-029 Read, WAIT_CYCLES=2, addr=4'h3, reg_ack on the first ACCESS cycle with reg_rdata=8'hA5 -> dev_ready_n low 5 clocks after the cs_s rise; rdata=8'hA5; rdata_oe=1; released 1 clock after cs_s falls.
REQ-030 Write, addr=4'h7, wdata=8'h3C, reg_ack after 4 cycles -> reg_req high for 5 cycles, reg_we=1, reg_addr=7, reg_wdata=8'h3C; rdata_oe stays 0.
REQ-031 cs with rd_n=wr_n=0 -> no reg_req; dev_ready_n low; rdata=8'hFF; rdata_oe=0.
REQ-032 cs drops during ACCESS, reg_ack pulsed 2 cycles later -> IDLE; dev_ready_n never low; rdata unchanged.
REQ-033 Macro defined, TIMEOUT_CYCLES=64, no reg_ack -> after 64 ACCESS cycles: timeout_flag=1, rdata=8'hFF, dev_ready_n low; flag persists into the next good transfer.
REQ-034 rst pulsed during SETUP with cs held high -> all outputs at reset values; a new transfer starts after the 2-clock resynchronization.
